icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped, read-only instruction-cache controller sitting between the fetch stage and the cache data RAM, a single-port synchronous RAM with 1-cycle registered read. It holds tags and valid bits internally, and drives the data RAM for lookups and refills. It fetches missing words from the memory/bus side over a valid/ready request channel and a valid-only response channel. It also supports whole-cache invalidation for fence.i and exports hit/miss counters.

## Interface
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, 64, word/line width (one word per line)
- LINES, 64, number of lines; power of two
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  fetch request
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_WIDTH  fetch byte address; bits [2:0] ignored
- resp_valid  out  1  one-cycle pulse, resp_data valid
- resp_data  out  DATA_WIDTH  fetched word
- flush  in  1  invalidate all lines (level or pulse)
- ram_addr  out  log2(LINES)  data-RAM index
- ram_cs_n  out  1  data-RAM chip select, active-low
- ram_we  out  1  data-RAM write enable
- ram_din  out  DATA_WIDTH  data-RAM write data
- ram_dout  in  DATA_WIDTH  data-RAM read data, valid 1 cycle after a read
- mem_req_valid  out  1  refill request
- mem_req_ready  in  1  bus accepts refill request
- mem_req_addr  out  ADDR_WIDTH  refill address, 8-byte aligned
- mem_resp_valid  in  1  refill data valid
- mem_resp_data  in  DATA_WIDTH  refill word
- hit_cnt, miss_cnt  out  32 each  saturating performance counters

## Operation
- Address split: index = addr[3+IW-1:3], with IW = log2(LINES); tag = addr[ADDR_WIDTH-1:3+IW].
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT.
- IDLE:
  - req_ready=1.
  - If a flush is pending or flush=1, all valid bits are cleared this cycle, the pending flag is cleared, and no request is accepted (req_ready=0 that cycle).
  - Otherwise, on req_valid: latch the address, drive ram_cs_n=0, ram_we=0, ram_addr=index, and go to LOOKUP.
- LOOKUP:
  - Hit (valid[index] && tag match): resp_valid=1, resp_data=ram_dout, hit_cnt++, go to IDLE.
  - Miss: miss_cnt++, go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr={addr[ADDR_WIDTH-1:3],3'b0}, held stable until mem_req_ready.
  - On the handshake, go to MISS_WAIT.
  - mem_resp_valid is ignored in this state.
- MISS_WAIT: on mem_resp_valid, in the same cycle:
  - drive ram_cs_n=0, ram_we=1, ram_din=mem_resp_data
  - write tag and set valid[index]
  - resp_valid=1, resp_data=mem_resp_data
  - go to IDLE
- Flush outside IDLE sets the pending flag. The in-flight request still completes and returns data; the flush is then applied in IDLE, including to the line just refilled.
- No response backpressure: the fetch stage must accept resp_valid.
- Counters saturate at 2^32-1.
- When the RAM is not being accessed, ram_cs_n=1 and ram_we=0.

## Timing
- Reset values: state IDLE, all valid=0, flush pending=0, req_ready=1, resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_addr=0, ram_cs_n=1, ram_we=0, ram_addr=0, ram_din=0, counters=0.
- Reset mid-miss abandons the miss. No mem_req_valid after reset; a late mem_resp_valid is ignored.
- Hit latency: request accepted in cycle N, resp_valid in cycle N+1. Throughput is one hit per 2 cycles.
- Miss latency: accept (N), LOOKUP (N+1), MISS_REQ from N+2 until the handshake, then resp_valid in the same cycle as mem_resp_valid.
- Flush takes 1 cycle in IDLE; a request can be accepted the following cycle.

## Structure
- Package icache_pkg holds:
  - state enum (IDLE, LOOKUP, MISS_REQ, MISS_WAIT)
  - derived widths INDEX_W, TAG_W, OFFSET_W=3
- Sub-module icache_tag_array holds the LINES × (TAG_W+1) flop array:
  - synchronous write port
  - combinational read
  - single-cycle clear-all
  - rst clears all entries
- The data RAM stays external.

## Test plan
- Cold miss: after reset, req_addr=0x8000_0000 → mem_req_addr=0x8000_0000. With mem_resp_data=0xDEAD_BEEF_0000_0013 → resp_valid in the same cycle with that data, ram_we=1, miss_cnt=1.
- Hit: repeat 0x8000_0000 → resp_valid one cycle after accept, data=0xDEAD_BEEF_0000_0013, no mem_req_valid, hit_cnt=1.
- Conflict: 0x8000_0200 (same index 0, different tag) → miss and refill. A following 0x8000_0000 → misses again.
- Bus stall: mem_req_ready held low 5 cycles → mem_req_valid and mem_req_addr stay stable. A mem_resp_valid pulse during MISS_REQ is ignored.
- Flush during MISS_WAIT → refill response still returned. The flush is applied in the next IDLE cycle with req_ready=0 for that cycle. The same address then misses.
- Reset asserted in MISS_WAIT → all outputs at reset values next cycle. A previously valid address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and derived widths for the direct-mapped instruction cache controller.
package icache_pkg;

    localparam int OFFSET_W      = 3;
    localparam int ADDR_W_DEF    = 64;
    localparam int LINES_DEF     = 64;
    localparam int INDEX_W       = $clog2(LINES_DEF);
    localparam int TAG_W         = ADDR_W_DEF - OFFSET_W - INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_REQ  = 2'd2,
        MISS_WAIT = 2'd3
    } state_t;

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Tag/valid store: one {valid, tag} flop entry per line, combinational read, single-cycle clear.
module icache_tag_array #(
    parameter int LINES = 64,
    parameter int TAG_W = 55,
    parameter int IW    = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [TAG_W-1:0] wtag,
    input  logic [IW-1:0]    raddr,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag
);

    logic [TAG_W:0] entry_r [LINES];

    // Entry update: clear-all wins over a refill write.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < LINES; i++) begin
                entry_r[i] <= {(TAG_W+1){1'b0}};
            end
        end else if (we) begin
            entry_r[waddr] <= {1'b1, wtag};
        end
    end

    assign rvalid = entry_r[raddr][TAG_W];
    assign rtag   = entry_r[raddr][TAG_W-1:0];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller driving an external 1-cycle data RAM.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINES      = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    output logic                          resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    input  logic                          flush,
    output logic [$clog2(LINES)-1:0]      ram_addr,
    output logic                          ram_cs_n,
    output logic                          ram_we,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr,
    input  logic                          mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]         mem_resp_data,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt
);

    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_WIDTH - OFFSET_W - IW;

    state_t                         state_r;
    logic [ADDR_WIDTH-OFFSET_W-1:0] line_r;
    logic                           flush_pend_r;
    logic [31:0]                    hit_cnt_r;
    logic [31:0]                    miss_cnt_r;

    logic [IW-1:0] idx_s;
    logic [TW-1:0] tag_s;
    logic [IW-1:0] req_idx_s;
    logic          tag_valid_s;
    logic [TW-1:0] tag_rd_s;
    logic          flush_now_s;
    logic          accept_s;
    logic          hit_s;
    logic          refill_s;
    logic          unused_s;

    assign idx_s       = line_r[IW-1:0];
    assign tag_s       = line_r[ADDR_WIDTH-OFFSET_W-1:IW];
    assign req_idx_s   = req_addr[OFFSET_W+IW-1:OFFSET_W];
    assign flush_now_s = (state_r == IDLE) && (flush_pend_r || flush);
    assign accept_s    = (state_r == IDLE) && !flush_now_s && req_valid;
    assign hit_s       = tag_valid_s && (tag_rd_s == tag_s);
    assign refill_s    = (state_r == MISS_WAIT) && mem_resp_valid;
    assign unused_s    = &{1'b0, req_addr[OFFSET_W-1:0]};

    icache_tag_array #(
        .LINES (LINES),
        .TAG_W (TW),
        .IW    (IW)
    ) u_tags (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush_now_s),
        .we     (refill_s),
        .waddr  (idx_s),
        .wtag   (tag_s),
        .raddr  (idx_s),
        .rvalid (tag_valid_s),
        .rtag   (tag_rd_s)
    );

    // Output decode; RAM and response strobes must land in the same cycle as their trigger.
    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = {DATA_WIDTH{1'b0}};
        ram_addr      = {IW{1'b0}};
        ram_cs_n      = 1'b1;
        ram_we        = 1'b0;
        ram_din       = {DATA_WIDTH{1'b0}};
        mem_req_valid = 1'b0;
        mem_req_addr  = {ADDR_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                req_ready = !flush_now_s;
                if (accept_s) begin
                    ram_cs_n = 1'b0;
                    ram_addr = req_idx_s;
                end else begin
                    ram_cs_n = 1'b1;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    resp_valid = 1'b1;
                    resp_data  = ram_dout;
                end else begin
                    resp_valid = 1'b0;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {line_r, {OFFSET_W{1'b0}}};
            end
            MISS_WAIT: begin
                if (mem_resp_valid) begin
                    ram_cs_n   = 1'b0;
                    ram_we     = 1'b1;
                    ram_addr   = idx_s;
                    ram_din    = mem_resp_data;
                    resp_valid = 1'b1;
                    resp_data  = mem_resp_data;
                end else begin
                    resp_valid = 1'b0;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Controller state, latched line address, deferred flush and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            line_r       <= {(ADDR_WIDTH-OFFSET_W){1'b0}};
            flush_pend_r <= 1'b0;
            hit_cnt_r    <= 32'd0;
            miss_cnt_r   <= 32'd0;
        end else begin
            if (flush_now_s) begin
                flush_pend_r <= 1'b0;
            end else if (flush) begin
                flush_pend_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        line_r  <= req_addr[ADDR_WIDTH-1:OFFSET_W];
                        state_r <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        hit_cnt_r <= sat_inc(hit_cnt_r);
                        state_r   <= IDLE;
                    end else begin
                        miss_cnt_r <= sat_inc(miss_cnt_r);
                        state_r    <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        state_r <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus randomized fetches against a line-level cache model.
module tb_icache_ctrl;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int LINES = 64;
    localparam int IW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          flush;
    logic [IW-1:0] ram_addr;
    logic          ram_cs_n;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which line address each index holds, and its data.
    bit            m_valid [LINES];
    logic [AW-1:0] m_line  [LINES];
    logic [DW-1:0] m_data  [LINES];
    int            m_hits   = 0;
    int            m_misses = 0;

    logic [DW-1:0] ram_mem [LINES];

    always #5 clk = ~clk;

    // External single-port data RAM with registered read.
    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    icache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINES(LINES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
        .ram_addr(ram_addr), .ram_cs_n(ram_cs_n), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[31:0], a[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'd0 ||
            mem_req_valid !== 1'b0 || mem_req_addr !== 64'd0 || ram_cs_n !== 1'b1 ||
            ram_we !== 1'b0 || ram_addr !== 6'd0 || ram_din !== 64'd0 ||
            hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: rdy=%b rv=%b rd=%h mv=%b ma=%h cs_n=%b we=%b ra=%h din=%h hc=%0d mc=%0d required 1 0 0 0 0 1 0 0 0 0 0",
                     tag, req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr,
                     ram_cs_n, ram_we, ram_addr, ram_din, hit_cnt, miss_cnt);
        end
    endtask

    // One complete fetch starting at a negedge in IDLE; outcome predicted by the model.
    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int stall, input int delay, input bit flush_wait);
        logic [5:0]    idx;
        logic [AW-1:0] line;
        bit            exp_hit;
        int            w;
        idx     = a[IW+2:3];
        line    = a >> 3;
        exp_hit = m_valid[idx] && (m_line[idx] == line);
        w = 0;
        while (!req_ready && w < 4) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        n_tests++;
        if (ram_cs_n !== 1'b0 || ram_we !== 1'b0 || ram_addr !== idx) begin
            n_fail++;
            $display("FAIL accept_ram: cs_n=%b we=%b addr=%0d required 0 0 %0d", ram_cs_n, ram_we, ram_addr, idx);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        #1;
        if (exp_hit) begin
            m_hits++;
            n_tests++;
            if (resp_valid !== 1'b1 || resp_data !== m_data[idx] || mem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hit_resp: valid=%b data=%h mreq=%b required 1 %h 0", resp_valid, resp_data, mem_req_valid, m_data[idx]);
            end
            @(negedge clk);
        end else begin
            m_misses++;
            n_tests++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_lookup: resp_valid=%b required 0", resp_valid);
            end
            @(negedge clk);
            for (int s = 0; s < stall; s++) begin
                mem_req_ready  = 1'b0;
                mem_resp_valid = (s == 0);
                mem_resp_data  = ~d;
                #1;
                n_tests++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== {a[63:3], 3'b000} ||
                    resp_valid !== 1'b0 || ram_cs_n !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold: mv=%b ma=%h rv=%b cs_n=%b required 1 %h 0 1",
                             mem_req_valid, mem_req_addr, resp_valid, ram_cs_n, {a[63:3], 3'b000});
                end
                @(negedge clk);
            end
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b1;
            #1;
            n_tests++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== {a[63:3], 3'b000}) begin
                n_fail++;
                $display("FAIL mem_req: mv=%b ma=%h required 1 %h", mem_req_valid, mem_req_addr, {a[63:3], 3'b000});
            end
            @(negedge clk);
            mem_req_ready = 1'b0;
            if (flush_wait) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
            for (int s = 0; s < delay; s++) begin
                #1;
                n_tests++;
                if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_idle: rv=%b mv=%b required 0 0", resp_valid, mem_req_valid);
                end
                @(negedge clk);
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = d;
            #1;
            n_tests++;
            if (resp_valid !== 1'b1 || resp_data !== d || ram_we !== 1'b1 || ram_cs_n !== 1'b0 ||
                ram_din !== d || ram_addr !== idx) begin
                n_fail++;
                $display("FAIL refill: rv=%b rd=%h we=%b cs_n=%b din=%h ra=%0d required 1 %h 1 0 %h %0d",
                         resp_valid, resp_data, ram_we, ram_cs_n, ram_din, ram_addr, d, d, idx);
            end
            @(negedge clk);
            mem_resp_valid = 1'b0;
            m_valid[idx] = 1'b1;
            m_line[idx]  = line;
            m_data[idx]  = d;
            if (flush_wait) begin
                #1;
                n_tests++;
                if (req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_apply: req_ready=%b required 0", req_ready);
                end
                model_clear();
                @(negedge clk);
            end
        end
        n_tests++;
        if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
            n_fail++;
            $display("FAIL counters: hit=%0d miss=%0d required %0d %0d", hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        fetch(64'h8000_0000, 64'hDEAD_BEEF_0000_0013, 0, 0, 1'b0);
        n_tests++;
        if (miss_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL cold_miss_cnt: miss_cnt=%0d required 1", miss_cnt);
        end
    endtask

    task automatic test_hit();
        fetch(64'h8000_0004, 64'h0, 0, 0, 1'b0);
        n_tests++;
        if (hit_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL hit_cnt: hit_cnt=%0d required 1", hit_cnt);
        end
    endtask

    task automatic test_conflict();
        fetch(64'h8000_0200, 64'h1111_2222_3333_4444, 1, 1, 1'b0);
        fetch(64'h8000_0000, 64'hDEAD_BEEF_0000_0013, 0, 2, 1'b0);
        n_tests++;
        if (miss_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL conflict_cnt: miss_cnt=%0d required 3", miss_cnt);
        end
    endtask

    task automatic test_bus_stall();
        fetch(64'h8000_010D, 64'hCAFE_F00D_1234_5678, 5, 3, 1'b0);
        fetch(64'h8000_0108, 64'h0, 0, 0, 1'b0);
    endtask

    task automatic test_flush_in_wait();
        fetch(64'h8000_0040, 64'h0BAD_0BAD_0BAD_0BAD, 1, 2, 1'b1);
        fetch(64'h8000_0040, 64'h0BAD_0BAD_0BAD_0BAE, 0, 0, 1'b0);
    endtask

    task automatic test_flush_idle();
        fetch(64'h8000_0000, 64'h0, 0, 0, 1'b0);
        flush = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_ready: req_ready=%b required 0", req_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle_after: req_ready=%b required 1", req_ready);
        end
        fetch(64'h8000_0000, 64'hDEAD_BEEF_0000_0013, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        fetch(64'h8000_0008, 64'h0808_0808_0808_0808, 0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            fetch((i % 2 == 0) ? 64'h8000_0008 : 64'h8000_0000, 64'h0, 0, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_miss();
        fetch(64'h8000_0000, 64'h0, 0, 0, 1'b0);
        req_valid = 1'b1;
        req_addr  = 64'h9000_0018;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("reset_mid_miss");
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h7777_7777_7777_7777;
        #1;
        n_tests++;
        if (resp_valid !== 1'b0 || ram_we !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL late_resp: rv=%b we=%b mv=%b required 0 0 0", resp_valid, ram_we, mem_req_valid);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        fetch(64'h8000_0000, 64'hDEAD_BEEF_0000_0013, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] bases [3];
        logic [AW-1:0] a;
        bases[0] = 64'h0000_0000_8000_0000;
        bases[1] = 64'h0000_0000_8000_0200;
        bases[2] = 64'hFFFF_FFFF_FFFF_FE00;
        for (int n = 0; n < 120; n++) begin
            a = bases[$urandom_range(0, 2)] + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
            fetch(a, mem_word(a >> 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr       = 64'd0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'd0;
        ram_dout       = 64'd0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_bus_stall();
        test_flush_in_wait();
        test_flush_idle();
        test_back_to_back();
        test_reset_mid_miss();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
